// File: rtl/pkg_dtypes.sv
// Shared front-end datatypes: issue-queue entry, EU index width and the
// dispatch-stage state/debug types.
package pkg_dtypes;

  localparam int NUM_PARALLEL_INSTR_DISPATCHES = 4;
  localparam int LOG2_NUM_EXEC_UNITS           = 2;
  localparam int NUM_EXEC_UNITS                = 2 ** LOG2_NUM_EXEC_UNITS;

  typedef logic [LOG2_NUM_EXEC_UNITS-1:0] type_euidx;

  typedef struct packed {
    logic [7:0] opcode;
    logic [5:0] dst_tag;
    logic [5:0] src1_tag;
    logic [5:0] src2_tag;
  } type_iqueue_entry;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } type_dispatch_state;

  typedef struct packed {
    type_dispatch_state state;
    type_euidx          rr_ptr;
  } type_dispatch_dbg;

endpackage

// File: rtl/fe_dispatch_euidx_alloc.sv
// Round-robin EU allocation for one batch: lane i gets rr_ptr plus the number
// of valid lanes below it, wrapping at the EU count.
module fe_dispatch_euidx_alloc
  import pkg_dtypes::*;
(
  input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]      lane_valid,
  input  type_euidx                                     rr_ptr,
  output type_euidx [NUM_PARALLEL_INSTR_DISPATCHES-1:0] euidx,
  output type_euidx                                     rr_ptr_next
);

  type_euidx acc;

  // Accumulating in the narrow index type gives the modulo wrap for free.
  always_comb begin
    euidx       = '0;
    acc         = rr_ptr;
    for (int i = 0; i < NUM_PARALLEL_INSTR_DISPATCHES; i++) begin
      euidx[i] = acc;
      acc      = acc + type_euidx'(lane_valid[i]);
    end
    rr_ptr_next = acc;
  end

endmodule

// File: rtl/fe_dispatch_unit.sv
// Dispatch stage: captures a renamed batch, assigns EUs round-robin and holds
// refused lanes on the registered dispatch bus until every lane is taken.
module fe_dispatch_unit
  import pkg_dtypes::*;
(
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0] batch_instr_i,
  input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]             batch_lane_valid_i,
  input  logic                                                 batch_valid_i,
  output logic                                                 batch_ready_o,
  input  logic                                                 flush_i,
  output type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0] dispatched_instr_o,
  output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]             dispatched_instr_valid_o,
  output type_euidx [NUM_PARALLEL_INSTR_DISPATCHES-1:0]        dispatched_instr_alloc_euidx_o,
  input  logic [NUM_EXEC_UNITS-1:0]                            eu_full_i,
  output logic [15:0]                                          stall_cycles_o,
  output type_dispatch_dbg                                     dbg_o
);

  localparam int N = NUM_PARALLEL_INSTR_DISPATCHES;

  type_dispatch_state     state_q;
  type_euidx              rr_ptr_q;
  type_euidx              rr_ptr_next;
  type_euidx [N-1:0]      alloc_euidx;
  logic      [N-1:0]      pending_next;
  logic                   capture;

  fe_dispatch_euidx_alloc u_alloc (
    .lane_valid  (batch_lane_valid_i),
    .rr_ptr      (rr_ptr_q),
    .euidx       (alloc_euidx),
    .rr_ptr_next (rr_ptr_next)
  );

  // A lane stays pending only if the EU it was bound to reports full now.
  always_comb begin
    pending_next = '0;
    for (int i = 0; i < N; i++) begin
      pending_next[i] = dispatched_instr_valid_o[i]
                        & eu_full_i[dispatched_instr_alloc_euidx_o[i]];
    end
  end

  // Handshake: a batch is taken at the rising edge where batch_valid_i and
  // batch_ready_o are both high. Ready depends only on state, eu_full_i and
  // flush_i, so it may rise in the cycle the last held lane drains, and a
  // flush cycle never takes a new batch.
  assign batch_ready_o = ~flush_i & ((state_q == ST_IDLE) | (pending_next == '0));
  assign capture       = batch_valid_i & batch_ready_o;

  assign dbg_o.state  = state_q;
  assign dbg_o.rr_ptr = rr_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q                        <= ST_IDLE;
      rr_ptr_q                       <= '0;
      stall_cycles_o                 <= '0;
      dispatched_instr_valid_o       <= '0;
      dispatched_instr_o             <= '0;
      dispatched_instr_alloc_euidx_o <= '0;
    end else begin
      if ((state_q == ST_DISPATCH) && (pending_next != '0) && (stall_cycles_o != 16'hFFFF)) begin
        stall_cycles_o <= stall_cycles_o + 16'd1;
      end

      if (flush_i) begin
        state_q                        <= ST_IDLE;
        dispatched_instr_valid_o       <= '0;
        dispatched_instr_o             <= '0;
        dispatched_instr_alloc_euidx_o <= '0;
      end else if (capture) begin
        // An all-invalid batch is consumed without a bus cycle or pointer move.
        if (|batch_lane_valid_i) begin
          state_q  <= ST_DISPATCH;
          rr_ptr_q <= rr_ptr_next;
        end else begin
          state_q  <= ST_IDLE;
        end
        dispatched_instr_valid_o <= batch_lane_valid_i;
        for (int i = 0; i < N; i++) begin
          dispatched_instr_o[i]             <= batch_lane_valid_i[i] ? batch_instr_i[i] : '0;
          dispatched_instr_alloc_euidx_o[i] <= batch_lane_valid_i[i] ? alloc_euidx[i] : '0;
        end
      end else begin
        state_q                  <= (pending_next != '0) ? ST_DISPATCH : ST_IDLE;
        dispatched_instr_valid_o <= pending_next;
        for (int i = 0; i < N; i++) begin
          if (!pending_next[i]) begin
            dispatched_instr_o[i]             <= '0;
            dispatched_instr_alloc_euidx_o[i] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fe_dispatch_unit.sv
// Scoreboard bench for fe_dispatch_unit: directed batches push expected bus
// snapshots; a negedge monitor pops one per cycle the bus shows a valid lane.
module tb_fe_dispatch_unit;
  import pkg_dtypes::*;

  localparam int N  = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam int IW = $bits(type_iqueue_entry);
  localparam int W  = N + N * LOG2_NUM_EXEC_UNITS + N * IW;
  localparam int CW = 128;

  logic                           clk;
  logic                           reset;
  type_iqueue_entry [N-1:0]       batch_instr_i;
  logic [N-1:0]                   batch_lane_valid_i;
  logic                           batch_valid_i;
  logic                           batch_ready_o;
  logic                           flush_i;
  type_iqueue_entry [N-1:0]       dispatched_instr_o;
  logic [N-1:0]                   dispatched_instr_valid_o;
  type_euidx [N-1:0]              dispatched_instr_alloc_euidx_o;
  logic [NUM_EXEC_UNITS-1:0]      eu_full_i;
  logic [15:0]                    stall_cycles_o;
  type_dispatch_dbg               dbg_o;

  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  fe_dispatch_unit dut (
    .clk                            (clk),
    .reset                          (reset),
    .batch_instr_i                  (batch_instr_i),
    .batch_lane_valid_i             (batch_lane_valid_i),
    .batch_valid_i                  (batch_valid_i),
    .batch_ready_o                  (batch_ready_o),
    .flush_i                        (flush_i),
    .dispatched_instr_o             (dispatched_instr_o),
    .dispatched_instr_valid_o       (dispatched_instr_valid_o),
    .dispatched_instr_alloc_euidx_o (dispatched_instr_alloc_euidx_o),
    .eu_full_i                      (eu_full_i),
    .stall_cycles_o                 (stall_cycles_o),
    .dbg_o                          (dbg_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  function automatic type_iqueue_entry mk_instr(input int id, input int lane);
    type_iqueue_entry e;
    e.opcode   = 8'(id);
    e.dst_tag  = 6'(lane + 8);
    e.src1_tag = 6'(id + lane);
    e.src2_tag = 6'(63 - lane);
    return e;
  endfunction

  // Expected bus snapshot; euidx is given packed {lane3,lane2,lane1,lane0}.
  function automatic logic [W-1:0] exp_bus(input logic [N-1:0] v, input logic [7:0] e, input int id);
    type_iqueue_entry [N-1:0] d;
    for (int i = 0; i < N; i++) d[i] = v[i] ? mk_instr(id, i) : '0;
    return {v, e, d};
  endfunction

  function automatic logic [W-1:0] bus_now();
    return {dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o};
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && (dispatched_instr_valid_o != '0)) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_bus: got %h expected no bus cycle (t=%0t)", bus_now(), $time);
        end else begin
          e = exp_q.pop_front();
          check("bus", CW'(bus_now()), CW'(e));
        end
      end
    end
  end

  // Driver tasks
  task automatic offer(input logic [N-1:0] lv, input int id, input logic chk_busy);
    @(negedge clk);
    batch_valid_i      = 1'b1;
    batch_lane_valid_i = lv;
    flush_i            = 1'b0;
    eu_full_i          = '0;
    for (int i = 0; i < N; i++) batch_instr_i[i] = mk_instr(id, i);
    #1;
    check("ready_offer", CW'(batch_ready_o), CW'(1'b1));
    if (chk_busy) check("no_bubble", CW'(dispatched_instr_valid_o != '0), CW'(1'b1));
  endtask

  task automatic step(input logic [NUM_EXEC_UNITS-1:0] full);
    @(negedge clk);
    batch_valid_i      = 1'b0;
    batch_lane_valid_i = '0;
    flush_i            = 1'b0;
    eu_full_i          = full;
    #1;
  endtask

  initial begin
    reset              = 1'b1;
    batch_valid_i      = 1'b0;
    batch_lane_valid_i = '0;
    batch_instr_i      = '0;
    flush_i            = 1'b0;
    eu_full_i          = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_ready", CW'(batch_ready_o), CW'(1'b1));
    check("reset_valid", CW'(dispatched_instr_valid_o), CW'(0));
    check("reset_stall", CW'(stall_cycles_o), CW'(0));
    check("reset_state", CW'(dbg_o.state), CW'(ST_IDLE));
    check("reset_rr", CW'(dbg_o.rr_ptr), CW'(0));

    // Full batch, all accepted: euidx 0..3, rr wraps back to 0.
    exp_q.push_back(exp_bus(4'b1111, 8'b11_10_01_00, 1));
    offer(4'b1111, 1, 1'b0);
    step('0);
    step('0);
    check("s1_idle", CW'(dispatched_instr_valid_o), CW'(0));
    check("s1_rr", CW'(dbg_o.rr_ptr), CW'(0));

    // Sparse batches: 1010 -> lanes1,3 = 0,1; then 0001 -> lane0 = 2.
    exp_q.push_back(exp_bus(4'b1010, 8'b01_00_00_00, 2));
    exp_q.push_back(exp_bus(4'b0001, 8'b00_00_00_10, 3));
    offer(4'b1010, 2, 1'b0);
    offer(4'b0001, 3, 1'b1);
    step('0);
    step('0);
    check("s2_rr", CW'(dbg_o.rr_ptr), CW'(3));

    // Re-align rr to 0, then hold EU2 full for 3 cycles.
    exp_q.push_back(exp_bus(4'b0001, 8'b00_00_00_11, 4));
    exp_q.push_back(exp_bus(4'b1111, 8'b11_10_01_00, 5));
    for (int k = 0; k < 3; k++) exp_q.push_back(exp_bus(4'b0100, 8'b00_10_00_00, 5));
    offer(4'b0001, 4, 1'b0);
    offer(4'b1111, 5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(4'b0100);
      check("stall_ready_low", CW'(batch_ready_o), CW'(1'b0));
    end
    step('0);
    check("drain_ready_high", CW'(batch_ready_o), CW'(1'b1));
    step('0);
    check("stall_idle", CW'(dispatched_instr_valid_o), CW'(0));
    check("stall_count", CW'(stall_cycles_o), CW'(3));
    check("stall_rr", CW'(dbg_o.rr_ptr), CW'(0));

    // Back-to-back batches, euidx wrapping 3 -> 0.
    exp_q.push_back(exp_bus(4'b1111, 8'b11_10_01_00, 6));
    exp_q.push_back(exp_bus(4'b0111, 8'b00_10_01_00, 7));
    exp_q.push_back(exp_bus(4'b1111, 8'b10_01_00_11, 8));
    exp_q.push_back(exp_bus(4'b1100, 8'b00_11_00_00, 9));
    offer(4'b1111, 6, 1'b0);
    offer(4'b0111, 7, 1'b1);
    offer(4'b1111, 8, 1'b1);
    offer(4'b1100, 9, 1'b1);
    step('0);
    check("b2b_last_busy", CW'(dispatched_instr_valid_o != '0), CW'(1'b1));
    step('0);
    check("b2b_rr", CW'(dbg_o.rr_ptr), CW'(1));

    // Hold lane0 on EU1, then flush with a competing batch offered.
    exp_q.push_back(exp_bus(4'b0001, 8'b00_00_00_01, 10));
    exp_q.push_back(exp_bus(4'b0001, 8'b00_00_00_01, 10));
    offer(4'b0001, 10, 1'b0);
    step(4'b0010);
    check("hold_ready_low", CW'(batch_ready_o), CW'(1'b0));
    @(negedge clk);
    eu_full_i          = 4'b0010;
    flush_i            = 1'b1;
    batch_valid_i      = 1'b1;
    batch_lane_valid_i = 4'b1111;
    for (int i = 0; i < N; i++) batch_instr_i[i] = mk_instr(11, i);
    #1;
    check("flush_ready_low", CW'(batch_ready_o), CW'(1'b0));
    step('0);
    check("flush_valid", CW'(dispatched_instr_valid_o), CW'(0));
    check("flush_state", CW'(dbg_o.state), CW'(ST_IDLE));
    check("flush_rr", CW'(dbg_o.rr_ptr), CW'(2));
    exp_q.push_back(exp_bus(4'b0001, 8'b00_00_00_10, 12));
    offer(4'b0001, 12, 1'b0);
    step('0);
    step('0);
    check("post_flush_rr", CW'(dbg_o.rr_ptr), CW'(3));

    // Asynchronous reset while lane1 is held on EU0.
    exp_q.push_back(exp_bus(4'b1111, 8'b10_01_00_11, 13));
    exp_q.push_back(exp_bus(4'b0010, 8'b00_00_00_00, 13));
    offer(4'b1111, 13, 1'b0);
    step(4'b0001);
    step(4'b0001);
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", CW'(dispatched_instr_valid_o), CW'(0));
    check("areset_data", CW'({dispatched_instr_alloc_euidx_o, dispatched_instr_o}), CW'(0));
    check("areset_stall", CW'(stall_cycles_o), CW'(0));
    check("areset_dbg", CW'(dbg_o), CW'({ST_IDLE, 2'd0}));
    @(negedge clk);
    reset     = 1'b0;
    eu_full_i = '0;
    #1;
    check("release_ready", CW'(batch_ready_o), CW'(1'b1));
    exp_q.push_back(exp_bus(4'b1111, 8'b11_10_01_00, 14));
    offer(4'b1111, 14, 1'b0);
    step('0);
    step('0);
    check("final_idle", CW'(dispatched_instr_valid_o), CW'(0));
    check("queue_empty", CW'(exp_q.size()), CW'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
